// File: rtl/mbuf_load_sched.sv
// mbuf_load_sched
// Load scheduler for the main operand buffer. Per job it pulls the weight group
// and the bias group once from the input stream. It then alternates between
// loading one IFM window group and issuing that window to the PE array, until
// num_windows windows have been consumed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_windows  job start pulse (sampled in idle) and window count
//   busy, done          job in progress / one-cycle end-of-job pulse
//   in_valid, in_ready  input stream handshake
//   in_data             input stream word
//   sel                 group code of the word on wr_data (00 = no write)
//   wr_en_ifm/wgt/bias  per-buffer write strobes, one cycle after the transfer
//   wr_data, wr_idx     registered word and its index within the group
//   window_valid/ready  window handshake with the PE array
//   window_count        windows consumed so far in the current job
module mbuf_load_sched #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IFM_WORDS  = 3,
    parameter int unsigned WGT_WORDS  = 3,
    parameter int unsigned BIAS_WORDS = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_windows,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [1:0]            sel,
    output logic                  wr_en_ifm,
    output logic                  wr_en_wgt,
    output logic                  wr_en_bias,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [3:0]            wr_idx,
    output logic                  window_valid,
    input  logic                  window_ready,
    output logic [CNT_WIDTH-1:0]  window_count
);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_IFM  = 2'b01;
    localparam logic [1:0] SEL_WGT  = 2'b10;
    localparam logic [1:0] SEL_BIAS = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoadWgt,
        StLoadBias,
        StLoadIfm,
        StIssue,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_WIDTH-1:0]  win_cnt_inc;
    logic [1:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [3:0]            wr_idx_q;

    logic                  transfer;
    logic                  last_word;
    logic [1:0]            grp_sel;
    logic [3:0]            grp_last;

    // Output decodes; everything here comes straight from registers.
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign window_valid = (state_q == StIssue);
    assign in_ready     = (state_q == StLoadWgt) || (state_q == StLoadBias) ||
                          (state_q == StLoadIfm);
    assign transfer     = in_valid && in_ready;
    assign win_cnt_inc  = win_cnt_q + CNT_WIDTH'(1);

    assign sel          = sel_q;
    assign wr_en_ifm    = (sel_q == SEL_IFM);
    assign wr_en_wgt    = (sel_q == SEL_WGT);
    assign wr_en_bias   = (sel_q == SEL_BIAS);
    assign wr_data      = wr_data_q;
    assign wr_idx       = wr_idx_q;
    assign window_count = win_cnt_q;

    // Group code and last-word index for the group being loaded.
    always_comb begin
        grp_sel  = SEL_NONE;
        grp_last = '0;
        unique case (state_q)
            StLoadWgt: begin
                grp_sel  = SEL_WGT;
                grp_last = 4'(WGT_WORDS - 1);
            end
            StLoadBias: begin
                grp_sel  = SEL_BIAS;
                grp_last = 4'(BIAS_WORDS - 1);
            end
            StLoadIfm: begin
                grp_sel  = SEL_IFM;
                grp_last = 4'(IFM_WORDS - 1);
            end
            default: begin
                grp_sel  = SEL_NONE;
                grp_last = '0;
            end
        endcase
    end

    assign last_word = (word_cnt_q == grp_last);

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        num_d      = num_q;
        win_cnt_d  = win_cnt_q;
        sel_d      = transfer ? grp_sel : SEL_NONE;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d     = num_windows;
                    win_cnt_d = '0;
                    state_d   = StLoadWgt;
                end
            end
            StLoadWgt: begin
                if (transfer && last_word) begin
                    state_d = StLoadBias;
                end
            end
            StLoadBias: begin
                if (transfer && last_word) begin
                    state_d = (num_q == '0) ? StDone : StLoadIfm;
                end
            end
            StLoadIfm: begin
                if (transfer && last_word) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (window_ready) begin
                    win_cnt_d = win_cnt_inc;
                    // Weights and bias stay resident: go back for the next IFM only.
                    state_d   = (win_cnt_inc == num_q) ? StDone : StLoadIfm;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (transfer) begin
            word_cnt_d = word_cnt_q + 4'd1;
        end
        // The word counter restarts on every state change.
        if (state_d != state_q) begin
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            num_q      <= '0;
            win_cnt_q  <= '0;
            sel_q      <= SEL_NONE;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            num_q      <= num_d;
            win_cnt_q  <= win_cnt_d;
            sel_q      <= sel_d;
        end
    end

    // Write data and index only move on a transfer; sel qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_q <= '0;
            wr_idx_q  <= '0;
        end else if (transfer) begin
            wr_data_q <= in_data;
            wr_idx_q  <= word_cnt_q;
        end
    end

endmodule

// File: tb/tb_mbuf_load_sched.sv
`timescale 1ns/1ps
module tb_mbuf_load_sched;

    localparam int DW   = 32;
    localparam int IFM  = 3;
    localparam int WGT  = 3;
    localparam int BIAS = 1;
    localparam int CW   = 16;
    localparam int WB   = WGT + BIAS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_windows;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    sel;
    logic          wr_en_ifm;
    logic          wr_en_wgt;
    logic          wr_en_bias;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_idx;
    logic          window_valid;
    logic          window_ready;
    logic [CW-1:0] window_count;

    int total = 0;
    int bad   = 0;

    mbuf_load_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_windows  (num_windows),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .sel          (sel),
        .wr_en_ifm    (wr_en_ifm),
        .wr_en_wgt    (wr_en_wgt),
        .wr_en_bias   (wr_en_bias),
        .wr_data      (wr_data),
        .wr_idx       (wr_idx),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .window_count (window_count)
    );

    always #5 clk = ~clk;

    // Expected write list for one job: weights, bias, then IFM groups.
    typedef struct {
        logic [1:0]    sel;
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } wr_t;

    wr_t expq[$];

    // Per-job results gathered by run_job.
    int r_err_rdy, r_err_wv, r_err_wr, r_err_busy, r_err_done, r_err_wc;
    int r_done_cyc, r_vld_cyc, r_nwr, r_timeout;

    function automatic logic [60:0] out_vec();
        return {busy, done, in_ready, window_valid, wr_en_ifm, wr_en_wgt, wr_en_bias,
                sel, wr_data, wr_idx, window_count};
    endfunction

    function automatic void build_exp(input int nw);
        wr_t e;
        expq.delete();
        for (int i = 0; i < WGT; i++) begin
            e.sel = 2'b10; e.idx = 4'(i); e.data = $urandom; expq.push_back(e);
        end
        for (int i = 0; i < BIAS; i++) begin
            e.sel = 2'b11; e.idx = 4'(i); e.data = $urandom; expq.push_back(e);
        end
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < IFM; i++) begin
                e.sel = 2'b01; e.idx = 4'(i); e.data = $urandom; expq.push_back(e);
            end
        end
    endfunction

    // Runs one job against a word/window-level model of the scheduler.
    // vmode: 0 in_valid=1, 1 alternate, 2 random. rmode: 0 ready=1, 1 random,
    // 2 hold low 5 cycles per window. glitch bit0: start during IFM load,
    // bit1: start together with done. abort_k >= 0: assert reset when word k strobes.
    task automatic run_job(input int nw, input int vmode, input int rmode,
                           input int glitch, input int abort_k);
        int sptr, hs, cyc, run, tw, pk;
        bit pend, done_passed, exp_done, need, exp_rdy, exp_wv, xfer, shake, glitched;
        sptr = 0; hs = 0; cyc = 0; run = 0; pk = 0;
        pend = 0; done_passed = 0; glitched = 0;
        r_err_rdy = 0; r_err_wv = 0; r_err_wr = 0; r_err_busy = 0; r_err_done = 0;
        r_err_wc = 0; r_done_cyc = -1; r_vld_cyc = 0; r_nwr = 0; r_timeout = 0;
        build_exp(nw);
        tw = expq.size();
        @(negedge clk);
        if (busy !== 1'b0) r_err_busy++;
        start        = 1'b1;
        num_windows  = CW'(nw);
        in_valid     = 1'b0;
        window_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc > 3000) begin
                r_timeout = 1;
                break;
            end
            exp_done = !done_passed && (sptr == tw) && (hs == nw);
            need     = (sptr < WB) || ((sptr < tw) && (sptr < WB + IFM * (hs + 1)));
            exp_rdy  = !done_passed && !exp_done && need;
            exp_wv   = !done_passed && !exp_done && !need && (hs < nw);

            if (busy !== !done_passed) r_err_busy++;
            if (done !== exp_done) r_err_done++;
            if (in_ready !== exp_rdy) r_err_rdy++;
            if (window_valid !== exp_wv) r_err_wv++;
            if (window_valid === 1'b1) r_vld_cyc++;
            if (!done_passed && window_count !== CW'(hs)) r_err_wc++;
            if (pend) begin
                r_nwr++;
                if (sel !== expq[pk].sel || wr_data !== expq[pk].data ||
                    wr_idx !== expq[pk].idx ||
                    {wr_en_ifm, wr_en_wgt, wr_en_bias} !==
                    {expq[pk].sel == 2'b01, expq[pk].sel == 2'b10, expq[pk].sel == 2'b11})
                    r_err_wr++;
            end else if (sel !== 2'b00 || wr_en_ifm !== 1'b0 || wr_en_wgt !== 1'b0 ||
                         wr_en_bias !== 1'b0) begin
                r_err_wr++;
            end

            if (pend && pk == abort_k) begin
                #1 rst_n = 1'b0;
                return;
            end
            if (done_passed) break;
            if (exp_done) begin
                done_passed = 1;
                r_done_cyc  = cyc;
                in_valid    = 1'b0;
                pend        = 0;
                if ((glitch & 2) != 0) start = 1'b1;
                continue;
            end

            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((cyc % 2) == 1);
                default: in_valid = ($urandom_range(99) < 70);
            endcase
            in_data = (sptr < tw) ? expq[sptr].data : $urandom;
            if (exp_wv) run++;
            else run = 0;
            case (rmode)
                0:       window_ready = 1'b1;
                1:       window_ready = ($urandom_range(1) == 1);
                default: window_ready = (run >= 6);
            endcase
            if ((glitch & 1) != 0 && !glitched && sptr == WB + 1 && exp_rdy) begin
                start       = 1'b1;
                num_windows = num_windows + CW'(5);
                glitched    = 1;
            end
            xfer  = in_valid && exp_rdy;
            shake = window_ready && exp_wv;
            pend  = xfer;
            pk    = sptr;
            if (xfer) sptr++;
            if (shake) hs++;
        end
        in_valid     = 1'b0;
        window_ready = 1'b0;
        start        = 1'b0;
    endtask

    task automatic test_reset();
        logic [60:0] v;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; window_ready = 1'b0;
        in_data = '0; num_windows = '0;
        #3;
        v = out_vec();
        total++;
        if (v !== '0) begin bad++; $display("FAIL reset_async got=%h want=0", v); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = out_vec();
        total++;
        if (v !== '0) begin bad++; $display("FAIL reset_idle got=%h want=0", v); end
    endtask

    task automatic test_basic();
        run_job(2, 0, 0, 0, -1);
        total++; if (r_timeout != 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", r_timeout); end
        total++; if (r_done_cyc != 13) begin bad++; $display("FAIL basic_done_cycle got=%0d want=13", r_done_cyc); end
        total++; if (r_nwr != 10) begin bad++; $display("FAIL basic_writes got=%0d want=10", r_nwr); end
        total++; if (r_err_wr != 0) begin bad++; $display("FAIL basic_wr_seq got=%0d want=0", r_err_wr); end
        total++; if (r_err_rdy != 0) begin bad++; $display("FAIL basic_in_ready got=%0d want=0", r_err_rdy); end
        total++; if (r_err_wv != 0) begin bad++; $display("FAIL basic_window_valid got=%0d want=0", r_err_wv); end
        total++; if (r_err_done != 0) begin bad++; $display("FAIL basic_done got=%0d want=0", r_err_done); end
        total++; if (r_err_busy != 0) begin bad++; $display("FAIL basic_busy got=%0d want=0", r_err_busy); end
        total++; if (r_err_wc != 0) begin bad++; $display("FAIL basic_window_count got=%0d want=0", r_err_wc); end
        total++; if (window_count !== CW'(2)) begin bad++; $display("FAIL basic_final_count got=%0d want=2", window_count); end
    endtask

    task automatic test_gaps();
        run_job(3, 1, 0, 0, -1);
        total++; if (r_timeout != 0) begin bad++; $display("FAIL gaps_timeout got=%0d want=0", r_timeout); end
        total++; if (r_nwr != 13) begin bad++; $display("FAIL gaps_writes got=%0d want=13", r_nwr); end
        total++; if (r_err_wr != 0) begin bad++; $display("FAIL gaps_wr_seq got=%0d want=0", r_err_wr); end
        total++; if (r_err_rdy != 0) begin bad++; $display("FAIL gaps_in_ready got=%0d want=0", r_err_rdy); end
    endtask

    task automatic test_stall();
        run_job(2, 0, 2, 0, -1);
        total++; if (r_vld_cyc != 12) begin bad++; $display("FAIL stall_valid_cycles got=%0d want=12", r_vld_cyc); end
        total++; if (r_err_wv != 0) begin bad++; $display("FAIL stall_window_valid got=%0d want=0", r_err_wv); end
        total++; if (r_err_rdy != 0) begin bad++; $display("FAIL stall_in_ready got=%0d want=0", r_err_rdy); end
        total++; if (r_err_wr != 0) begin bad++; $display("FAIL stall_wr_seq got=%0d want=0", r_err_wr); end
    endtask

    task automatic test_zero();
        run_job(0, 0, 0, 0, -1);
        total++; if (r_vld_cyc != 0) begin bad++; $display("FAIL zero_valid_cycles got=%0d want=0", r_vld_cyc); end
        total++; if (r_nwr != 4) begin bad++; $display("FAIL zero_writes got=%0d want=4", r_nwr); end
        total++; if (r_done_cyc != 5) begin bad++; $display("FAIL zero_done_cycle got=%0d want=5", r_done_cyc); end
        total++; if (r_err_done != 0) begin bad++; $display("FAIL zero_done got=%0d want=0", r_err_done); end
    endtask

    task automatic test_start_ignored();
        int busy_hits;
        run_job(2, 2, 1, 3, -1);
        total++; if (r_nwr != 10) begin bad++; $display("FAIL ign_writes got=%0d want=10", r_nwr); end
        total++; if (r_err_wc != 0) begin bad++; $display("FAIL ign_window_count got=%0d want=0", r_err_wc); end
        total++; if (r_err_wr != 0) begin bad++; $display("FAIL ign_wr_seq got=%0d want=0", r_err_wr); end
        total++; if (r_err_busy != 0) begin bad++; $display("FAIL ign_busy got=%0d want=0", r_err_busy); end
        busy_hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_hits++;
        end
        total++; if (busy_hits != 0) begin bad++; $display("FAIL ign_no_restart got=%0d want=0", busy_hits); end
    endtask

    task automatic test_reset_mid();
        logic [60:0] v;
        run_job(2, 0, 0, 0, WB + IFM + 1);
        #1;
        v = out_vec();
        total++; if (v !== '0) begin bad++; $display("FAIL rstmid_async got=%h want=0", v); end
        in_valid = 1'b0; window_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = out_vec();
        total++; if (v !== '0) begin bad++; $display("FAIL rstmid_idle got=%h want=0", v); end
        run_job(1, 0, 0, 0, -1);
        total++; if (r_err_wr != 0) begin bad++; $display("FAIL rstmid_reload got=%0d want=0", r_err_wr); end
        total++; if (r_done_cyc != 9) begin bad++; $display("FAIL rstmid_done_cycle got=%0d want=9", r_done_cyc); end
    endtask

    task automatic test_random();
        int nw, errs;
        for (int j = 0; j < 6; j++) begin
            nw = int'($urandom_range(4));
            run_job(nw, 2, 1, 0, -1);
            errs = r_err_rdy + r_err_wv + r_err_wr + r_err_busy + r_err_done + r_err_wc;
            total++; if (r_timeout != 0) begin bad++; $display("FAIL rand_timeout job=%0d got=%0d want=0", j, r_timeout); end
            total++; if (errs != 0) begin bad++; $display("FAIL rand_job job=%0d nw=%0d got=%0d want=0", j, nw, errs); end
            total++; if (r_nwr != WB + IFM * nw) begin bad++; $display("FAIL rand_writes job=%0d got=%0d want=%0d", j, r_nwr, WB + IFM * nw); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_stall();
        test_zero();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbuf_load_sched.md
# mbuf_load_sched

Load scheduler for the main operand buffer of the CNN accelerator. It replaces free-running slot counting with a handshaked sequence. For each job it fetches the weight words and the bias word once from the 32-bit input stream. It then repeatedly fetches one IFM window group and hands the completed window to the PE array, until the requested number of windows has been consumed. It drives the buffer select code and the per-buffer write strobes, and stalls cleanly on either side.

## Interface
- DATA_WIDTH, 32: input stream and write-data width.
- IFM_WORDS, 3: stream words per IFM window group.
- WGT_WORDS, 3: stream words per weight group.
- BIAS_WORDS, 1: stream words per bias group.
- CNT_WIDTH, 16: width of the window count.
- IFM / WGT / BIAS, 2'b01 / 2'b10 / 2'b11: select codes. 2'b00 means no write.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job start pulse; sampled only in IDLE.
- num_windows  in  CNT_WIDTH  windows in this job; captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at job end.
- in_valid  in  1  stream word valid.
- in_ready  out  1  scheduler accepts the word (high in LOAD_WGT, LOAD_BIAS, LOAD_IFM).
- in_data  in  DATA_WIDTH  stream word.
- sel  out  2  group code of the word currently on wr_data; 00 when nothing is written.
- wr_en_ifm / wr_en_wgt / wr_en_bias  out  1  write strobe to the matching buffer.
- wr_data  out  DATA_WIDTH  registered copy of the accepted word.
- wr_idx  out  4  word index within its group, 0-based.
- window_valid  out  1  a complete IFM window plus weights/bias is ready for the PE array.
- window_ready  in  1  PE array consumes the window.
- window_count  out  CNT_WIDTH  windows consumed so far in the current job.

## Operation
- States: IDLE, LOAD_WGT, LOAD_BIAS, LOAD_IFM, ISSUE, DONE.
- Transfer means in_valid && in_ready. A word counter advances on each transfer and clears on every state change.
- IDLE:
  - If start is high, capture num_windows, clear window_count, and go to LOAD_WGT.
  - start is ignored in every other state.
- LOAD_WGT: after WGT_WORDS transfers, go to LOAD_BIAS.
- LOAD_BIAS: after BIAS_WORDS transfers:
  - go to DONE if the captured num_windows == 0;
  - otherwise go to LOAD_IFM.
- LOAD_IFM: after IFM_WORDS transfers, go to ISSUE.
- ISSUE: window_valid=1 and in_ready=0. On window_ready, window_count increments, then:
  - if the new count equals the captured num_windows, go to DONE;
  - otherwise go to LOAD_IFM.
  - Weights and bias stay resident and are not reloaded.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Write path: on every transfer, the next cycle presents:
  - sel = the current group code;
  - the matching wr_en_* = 1;
  - wr_data = in_data;
  - wr_idx = the word counter value at transfer.
  - In every cycle without a preceding transfer, sel=00 and all wr_en_*=0. At most one wr_en_* is high in any cycle.
- A gap with in_valid low during a load holds the state and counter, and produces no write.
- window_count does not wrap within a job; num_windows is at most 2^CNT_WIDTH-1.

## Timing
- Reset values:
  - state IDLE;
  - busy, done, in_ready, window_valid, all wr_en_* = 0;
  - sel=00, wr_data=0, wr_idx=0, window_count=0.
- Reset is asserted asynchronously at any point, including mid-load or mid-ISSUE. It returns the block to IDLE immediately and discards the partial group; no further write strobes are issued.
- in_ready is a decode of the state. A transfer in the last word of a group is followed by in_ready=0 for at least one cycle only when the next state is ISSUE or DONE. LOAD_WGT→LOAD_BIAS→LOAD_IFM accept back-to-back words with no bubble.
- Write latency: 1 cycle from transfer to strobe.
- The last IFM strobe occurs in the same cycle window_valid first rises. The PE array may therefore sample the buffer no earlier than the window_ready handshake cycle.
- window_valid stays high until window_ready and does not depend on window_ready combinationally.
- Minimum per-window period: IFM_WORDS + 1 cycles.
- Minimum job length: 1 cycle start accept + (WGT_WORDS + BIAS_WORDS) + num_windows*(IFM_WORDS+1) + 1 DONE cycle.

## Test plan
- Reset, then start with num_windows=2 and in_valid always 1, window_ready always 1 → strobe sequence:
  - wgt idx 0,1,2;
  - bias 0;
  - ifm 0,1,2, window;
  - ifm 0,1,2, window;
  - done pulse; window_count=2; 14 cycles from start to done.
- in_valid low every other cycle during the loads → same strobe order and data, no duplicated or skipped wr_idx, in_ready high throughout each load.
- window_ready held low 5 cycles in ISSUE → window_valid stays high 5+1 cycles, in_ready=0, no strobes.
- num_windows=0 → weight and bias loads only, then done; window_valid never rises.
- start pulsed during LOAD_IFM, and pulsed together with done → ignored; no restart, captured count unchanged.
- rst_n asserted on the 2nd IFM word of window 1 → all outputs at reset values in that cycle. A new start reloads weights from idx 0.
